// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clk_sched_pkg;

  localparam int unsigned DIV_W = 32;
  localparam logic [DIV_W-1:0] DEFAULT_DIV = 32'd25_000_000;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    mode_t            mode;
  } cfg_t;

  // Map the raw 2-bit request onto a mode; the unused code 11 means HALT.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'b01:   m = MODE_RUN;
      2'b10:   m = MODE_STEP;
      default: m = MODE_HALT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clk_en_sched_edge_rise.sv
// One-bit rising-edge detector with a registered history bit.
// rise is high in the cycle where d is 1 and was 0 on the previous cycle.
module edge_rise (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  // Next history is simply the current input level.
  always_comb begin
    hist_d = d;
  end

  // History register, cleared on reset so a level high at release counts as an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise = d & ~hist_q;

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: issues a one-cycle tick in RUN (every div cycles),
// STEP (one per step-button rising edge) or HALT (never). New settings arrive
// through a one-entry config slot and take effect only at a period boundary.
module clk_en_sched #(
  parameter int unsigned       CNT_W       = 32,
  parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(clk_sched_pkg::DEFAULT_DIV),
  parameter int unsigned       TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic              step,
  output logic              tick,
  output logic [1:0]        mode,
  output logic [CNT_W-1:0]  div_active,
  output logic [TCNT_W-1:0] tick_count
);

  import clk_sched_pkg::*;

  mode_t             mode_q,       mode_d;
  logic [CNT_W-1:0]  div_q,        div_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              tick_q,       tick_d;
  logic [TCNT_W-1:0] tcnt_q,       tcnt_d;
  cfg_t              pend_q,       pend_d;
  logic              pend_valid_q, pend_valid_d;

  logic              step_rise_s;
  logic              accept_s;
  logic              boundary_s;
  logic              apply_s;
  logic [CNT_W-1:0]  req_div_s;

  edge_rise u_step_edge (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (step),
    .rise  (step_rise_s)
  );

  assign accept_s  = cfg_valid & ~pend_valid_q;
  // A zero divide value would never reach a boundary; run it as divide-by-1.
  assign req_div_s = (cfg_div == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_div;

  // Next-state logic: period counter, tick generation, config slot and apply point.
  always_comb begin
    mode_d       = mode_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    boundary_s   = 1'b0;
    apply_s      = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        // >= rather than == so a counter left above a newly shrunk div still ends the period.
        boundary_s = (cnt_q >= (div_q - {{(CNT_W-1){1'b0}}, 1'b1}));
        if (boundary_s) begin
          tick_d = 1'b1;
          cnt_d  = {CNT_W{1'b0}};
        end else begin
          cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      MODE_STEP: begin
        tick_d = step_rise_s;
        cnt_d  = {CNT_W{1'b0}};
      end
      default: begin
        cnt_d  = {CNT_W{1'b0}};
      end
    endcase

    // RUN only switches at the end of a period; other modes switch right away.
    apply_s = pend_valid_q & ((mode_q != MODE_RUN) | boundary_s);

    if (apply_s) begin
      mode_d       = pend_q.mode;
      div_d        = CNT_W'(pend_q.div);
      cnt_d        = {CNT_W{1'b0}};
      pend_valid_d = 1'b0;
    end else if (accept_s) begin
      pend_d.div   = DIV_W'(req_div_s);
      pend_d.mode  = decode_mode(cfg_mode);
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    // Count the tick in the same cycle it is presented on the output.
    tcnt_d = tcnt_q + {{(TCNT_W-1){1'b0}}, tick_d};
  end

  // State registers; reset drops any pending config and returns to HALT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q       <= MODE_HALT;
      div_q        <= DEFAULT_DIV;
      cnt_q        <= {CNT_W{1'b0}};
      tick_q       <= 1'b0;
      tcnt_q       <= {TCNT_W{1'b0}};
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      tcnt_q       <= tcnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign tick       = tick_q;
  assign mode       = mode_q;
  assign div_active = div_q;
  assign tick_count = tcnt_q;
  assign cfg_ready  = ~pend_valid_q;

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched: inputs change on the falling edge and
// outputs are sampled there too, half a cycle after each rising edge.
module tb_clk_en_sched;

  logic        clk;
  logic        n_rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic [1:0]  cfg_mode;
  logic        step;
  logic        tick;
  logic [1:0]  mode;
  logic [31:0] div_active;
  logic [15:0] tick_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt = 0;

  localparam logic [31:0] DEF_DIV = 32'd25_000_000;

  clk_en_sched dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_mode   (cfg_mode),
    .step       (step),
    .tick       (tick),
    .mode       (mode),
    .div_active (div_active),
    .tick_count (tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one config request for exactly one rising edge.
  task automatic send(input logic [31:0] d, input logic [1:0] m);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_mode  = m;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic check_tick_seen();
    exp_cnt++;
    check_val("tick", 32'(tick), 32'd1);
    check_val("tick_count", 32'(tick_count), 32'(exp_cnt & 16'hFFFF));
  endtask

  initial begin
    n_rst     = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 32'd0;
    cfg_mode  = 2'b00;
    step      = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_mode", 32'(mode), 32'd0);
    check_val("rst_div", div_active, DEF_DIV);
    check_val("rst_tcnt", 32'(tick_count), 32'd0);
    check_val("rst_ready", 32'(cfg_ready), 32'd1);

    // RUN div=4: applied one cycle after acceptance, first tick 4 cycles later
    send(32'd4, 2'b01);
    check_val("t1_ready_low", 32'(cfg_ready), 32'd0);
    check_val("t1_mode_pre", 32'(mode), 32'd0);
    cyc();
    check_val("t1_mode", 32'(mode), 32'd1);
    check_val("t1_div", div_active, 32'd4);
    check_val("t1_ready_back", 32'(cfg_ready), 32'd1);
    check_val("t1_tick0", 32'(tick), 32'd0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) begin
        cyc();
        check_val("t1_gap", 32'(tick), 32'd0);
      end
      cyc();
      check_tick_seen();
    end

    // div=2 requested mid-period: current period keeps 4 cycles
    cyc();
    check_val("t2_a", 32'(tick), 32'd0);
    send(32'd2, 2'b01);
    check_val("t2_ready_low", 32'(cfg_ready), 32'd0);
    check_val("t2_b", 32'(tick), 32'd0);
    cyc();
    check_val("t2_c", 32'(tick), 32'd0);
    check_val("t2_ready_still_low", 32'(cfg_ready), 32'd0);
    check_val("t2_div_old", div_active, 32'd4);
    cyc();
    check_tick_seen();
    check_val("t2_div_new", div_active, 32'd2);
    check_val("t2_ready_back", 32'(cfg_ready), 32'd1);
    for (int p = 0; p < 2; p++) begin
      cyc();
      check_val("t2_gap", 32'(tick), 32'd0);
      cyc();
      check_tick_seen();
    end

    // div=0 is treated as 1: tick every cycle
    send(32'd0, 2'b01);
    check_val("t3_a", 32'(tick), 32'd0);
    cyc();
    check_tick_seen();
    check_val("t3_div", div_active, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_tick_seen();
    end

    // Switch to STEP (waits for the RUN boundary, which is every cycle here)
    send(32'd1, 2'b10);
    check_tick_seen();
    check_val("t4_ready_low", 32'(cfg_ready), 32'd0);
    cyc();
    check_tick_seen();
    check_val("t4_mode", 32'(mode), 32'd2);
    check_val("t4_ready_back", 32'(cfg_ready), 32'd1);
    cyc();
    check_val("t4_idle", 32'(tick), 32'd0);
    // Held step: exactly one tick, one cycle after the edge
    step = 1'b1;
    cyc();
    check_tick_seen();
    for (int i = 0; i < 9; i++) begin
      cyc();
      check_val("t4_held", 32'(tick), 32'd0);
    end
    step = 1'b0;
    cyc();
    check_val("t4_release", 32'(tick), 32'd0);
    check_val("t4_tcnt", 32'(tick_count), 32'(exp_cnt));

    // Mode code 11 means HALT; step edges are then ignored
    send(32'd0, 2'b11);
    check_val("t5_a", 32'(tick), 32'd0);
    cyc();
    check_val("t5_mode", 32'(mode), 32'd0);
    check_val("t5_div", div_active, 32'd1);
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("t5_halt_step", 32'(tick), 32'd0);
    end
    step = 1'b0;
    cyc();
    check_val("t5_tcnt", 32'(tick_count), 32'(exp_cnt));

    // Second request while the slot is full is held off until after apply
    cfg_valid = 1'b1;
    cfg_div   = 32'd3;
    cfg_mode  = 2'b01;
    cyc();
    cfg_div   = 32'd5;
    cfg_mode  = 2'b10;
    check_val("t6_ready_full", 32'(cfg_ready), 32'd0);
    cyc();
    check_val("t6_mode_a", 32'(mode), 32'd1);
    check_val("t6_div_a", div_active, 32'd3);
    check_val("t6_ready_free", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0;
    check_val("t6_ready_b", 32'(cfg_ready), 32'd0);
    check_val("t6_tick_b", 32'(tick), 32'd0);
    cyc();
    check_val("t6_mode_still_run", 32'(mode), 32'd1);
    check_val("t6_tick_c", 32'(tick), 32'd0);
    cyc();
    check_tick_seen();
    check_val("t6_mode_b", 32'(mode), 32'd2);
    check_val("t6_div_b", div_active, 32'd5);
    check_val("t6_ready_end", 32'(cfg_ready), 32'd1);
    cyc();
    check_val("t6_tick_after", 32'(tick), 32'd0);

    // Reset mid-period with a pending config
    send(32'd4, 2'b01);
    cyc();
    check_val("t7_mode_run", 32'(mode), 32'd1);
    cyc();
    cyc();
    send(32'd7, 2'b00);
    check_val("t7_ready_low", 32'(cfg_ready), 32'd0);
    n_rst = 1'b0;
    #1;
    check_val("t7_rst_mode", 32'(mode), 32'd0);
    check_val("t7_rst_div", div_active, DEF_DIV);
    check_val("t7_rst_tcnt", 32'(tick_count), 32'd0);
    check_val("t7_rst_ready", 32'(cfg_ready), 32'd1);
    check_val("t7_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_val("t7_post_tick", 32'(tick), 32'd0);
      check_val("t7_post_mode", 32'(mode), 32'd0);
    end
    check_val("t7_post_div", div_active, DEF_DIV);
    check_val("t7_post_tcnt", 32'(tick_count), 32'd0);
    check_val("t7_post_ready", 32'(cfg_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
